// File: rtl/huffman_decoder_canon.sv
`default_nettype none
// ============================================================================
// Module   : huffman_decoder_canon
// Brief    : Bit-serial canonical Huffman decoder with ready/valid handshakes.
//            Define HUFFDEC_CFG_EN for runtime-writable count/symbol tables.
// Revision : 1.0
// ============================================================================
module huffman_decoder_canon #(
    parameter int SYM_W   = 3,
    parameter int MAX_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [SYM_W-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             err,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [SYM_W-1:0] cfg_addr,
    input  logic [SYM_W:0]   cfg_data
);

    localparam int c_NSYM = 2 ** SYM_W;
    localparam int c_LW   = $clog2(MAX_LEN + 1);
    // Wide enough that first[] cannot wrap even for oversubscribed tables
    localparam int c_TW   = MAX_LEN + SYM_W + 3;

    function automatic logic [SYM_W:0] f_dflt_count(input int l);
        case (l)
            1:       return (SYM_W+1)'(1);
            3:       return (SYM_W+1)'(3);
            4:       return (SYM_W+1)'(2);
            default: return '0;
        endcase
    endfunction

    logic [SYM_W:0]     w_count [1:MAX_LEN];
    logic [SYM_W-1:0]   w_sym   [0:c_NSYM-1];
    logic [c_TW-1:0]    w_first [1:MAX_LEN];
    logic [c_TW-1:0]    w_base  [1:MAX_LEN];
    logic               w_cfg_wr;

    logic [MAX_LEN-2:0] r_code;
    logic [c_LW-1:0]    r_len;

    logic [MAX_LEN-1:0] w_code_next;
    logic [c_LW-1:0]    w_len_next;
    logic [c_TW-1:0]    w_code_ext;
    logic [c_TW-1:0]    w_sel_first;
    logic [c_TW-1:0]    w_sel_base;
    logic [SYM_W:0]     w_sel_count;
    logic [c_TW-1:0]    w_idx;
    logic               w_hit;
    logic               w_idx_bad;
    logic               w_full;
    logic               w_accept;

`ifdef HUFFDEC_CFG_EN
    logic [SYM_W:0]   r_count [1:MAX_LEN];
    logic [SYM_W-1:0] r_sym   [0:c_NSYM-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int l = 1; l <= MAX_LEN; l++) r_count[l] <= f_dflt_count(l);
            for (int i = 0; i < c_NSYM; i++)   r_sym[i]   <= SYM_W'(i);
        end else if (cfg_we) begin
            if (cfg_sel) begin
                r_sym[cfg_addr] <= cfg_data[SYM_W-1:0];
            end else begin
                // Addresses 0 and above MAX_LEN match no entry and are dropped
                for (int l = 1; l <= MAX_LEN; l++) begin
                    if (cfg_addr == SYM_W'(l)) r_count[l] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        for (int l = 1; l <= MAX_LEN; l++) w_count[l] = r_count[l];
        for (int i = 0; i < c_NSYM; i++)   w_sym[i]   = r_sym[i];
    end

    assign w_cfg_wr = cfg_we;
`else
    logic w_unused_cfg;

    always_comb begin
        for (int l = 1; l <= MAX_LEN; l++) w_count[l] = f_dflt_count(l);
        for (int i = 0; i < c_NSYM; i++)   w_sym[i]   = SYM_W'(i);
    end

    assign w_cfg_wr     = 1'b0;
    assign w_unused_cfg = ^{cfg_we, cfg_sel, cfg_addr, cfg_data};
`endif

    always_comb begin
        w_first[1] = '0;
        w_base[1]  = '0;
        for (int l = 2; l <= MAX_LEN; l++) begin
            w_first[l] = (w_first[l-1] + c_TW'(w_count[l-1])) << 1;
            w_base[l]  = w_base[l-1] + c_TW'(w_count[l-1]);
        end
    end

    assign w_code_next = {r_code, x};
    assign w_len_next  = r_len + c_LW'(1);
    assign w_code_ext  = c_TW'(w_code_next);

    always_comb begin
        w_sel_first = '0;
        w_sel_base  = '0;
        w_sel_count = '0;
        for (int l = 1; l <= MAX_LEN; l++) begin
            if (w_len_next == c_LW'(l)) begin
                w_sel_first = w_first[l];
                w_sel_base  = w_base[l];
                w_sel_count = w_count[l];
            end
        end
    end

    assign w_hit     = (w_code_ext >= w_sel_first) &&
                       ((w_code_ext - w_sel_first) < c_TW'(w_sel_count));
    assign w_idx     = w_sel_base + w_code_ext - w_sel_first;
    assign w_idx_bad = (w_idx >= c_TW'(c_NSYM));
    assign w_full    = (w_len_next == c_LW'(MAX_LEN));

    assign x_ready  = !y_valid || y_ready;
    assign w_accept = x_valid && x_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y       <= '0;
            y_valid <= 1'b0;
            err     <= 1'b0;
            r_code  <= '0;
            r_len   <= '0;
        end else begin
            err <= 1'b0;
            if (y_valid && y_ready) y_valid <= 1'b0;

            // A table write invalidates any partially shifted code
            if (w_cfg_wr) begin
                r_code <= '0;
                r_len  <= '0;
            end else if (w_accept) begin
                if (w_hit && !w_idx_bad) begin
                    y       <= w_sym[w_idx[SYM_W-1:0]];
                    y_valid <= 1'b1;
                    r_code  <= '0;
                    r_len   <= '0;
                end else if (w_hit || w_full) begin
                    err    <= 1'b1;
                    r_code <= '0;
                    r_len  <= '0;
                end else begin
                    r_code <= w_code_next[MAX_LEN-2:0];
                    r_len  <= w_len_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huffman_decoder_canon.sv
`default_nettype none
// Testbench for huffman_decoder_canon: directed scenarios plus a randomized
// run checked against a codebook-lookup reference model.
module tb_huffman_decoder_canon;

    localparam int SYM_W   = 3;
    localparam int MAX_LEN = 4;
    localparam int NSYM    = 2 ** SYM_W;

    logic             clk;
    logic             reset;
    logic             x;
    logic             x_valid;
    logic             x_ready;
    logic [SYM_W-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             err;
    logic             cfg_we;
    logic             cfg_sel;
    logic [SYM_W-1:0] cfg_addr;
    logic [SYM_W:0]   cfg_data;

    int n_checks;
    int n_fail;

    // Reference codebook: one entry per canonical code, in symbol-table order
    int cb_val[$];
    int cb_len[$];
    int m_count[1:MAX_LEN];
    int m_sym[0:NSYM-1];

    huffman_decoder_canon #(.SYM_W(SYM_W), .MAX_LEN(MAX_LEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .err      (err),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_codebook();
        int code;
        cb_val.delete();
        cb_len.delete();
        code = 0;
        for (int l = 1; l <= MAX_LEN; l++) begin
            for (int k = 0; k < m_count[l]; k++) begin
                cb_val.push_back(code);
                cb_len.push_back(l);
                code++;
            end
            code = code * 2;
        end
    endtask

    task automatic send_bit(input logic b);
        x       = b;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b want 0", y_valid); end
        n_checks++; if (y !== '0)         begin n_fail++; $display("FAIL reset_y: got %0d want 0", y); end
        n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL reset_x_ready: got %b want 1", x_ready); end
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_zero();
        y_ready = 1'b1;
        send_bit(1'b0);
        n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL zero_y_valid: got %b want 1", y_valid); end
        n_checks++; if (y !== 3'd0)       begin n_fail++; $display("FAIL zero_y: got %0d want 0", y); end
        @(posedge clk);
        #1;
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL zero_take: got %b want 0", y_valid); end
    endtask

    task automatic test_streams();
        int cv[5] = '{4, 5, 6, 14, 15};
        int cl[5] = '{3, 3, 3, 4, 4};
        y_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            for (int b = cl[c] - 1; b >= 0; b--) begin
                send_bit(1'((cv[c] >> b) & 1));
                n_checks++;
                if (err !== 1'b0) begin n_fail++; $display("FAIL stream_err code %0d: got %b want 0", c, err); end
                n_checks++;
                if (y_valid !== (b == 0)) begin
                    n_fail++; $display("FAIL stream_y_valid code %0d bit %0d: got %b want %b", c, b, y_valid, (b == 0));
                end
                if (b == 0) begin
                    n_checks++;
                    if (y !== SYM_W'(c + 1)) begin n_fail++; $display("FAIL stream_y code %0d: got %0d want %0d", c, y, c + 1); end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        y_ready = 1'b0;
        x       = 1'b0;
        x_valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid: got %b want 1", y_valid); end
        n_checks++; if (y !== 3'd0)       begin n_fail++; $display("FAIL bp_first_y: got %0d want 0", y); end
        n_checks++; if (x_ready !== 1'b0) begin n_fail++; $display("FAIL bp_x_ready: got %b want 0", x_ready); end
        @(posedge clk);
        #1;
        n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid: got %b want 1", y_valid); end
        y_ready = 1'b1;
        #1;
        n_checks++; if (x_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_x_ready: got %b want 1", x_ready); end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b want 1", y_valid); end
        n_checks++; if (y !== 3'd0)       begin n_fail++; $display("FAIL bp_second_y: got %0d want 0", y); end
        @(posedge clk);
        #1;
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", y_valid); end
    endtask

`ifdef HUFFDEC_CFG_EN
    task automatic cfg_write(input logic sel, input int addr, input int data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = SYM_W'(addr);
        cfg_data = (SYM_W+1)'(data);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic test_cfg_err();
        y_ready = 1'b1;
        cfg_write(1'b0, 3, 0);
        cfg_write(1'b0, 4, 0);
        for (int b = 0; b < 4; b++) begin
            send_bit(1'b1);
            n_checks++;
            if (err !== (b == 3)) begin n_fail++; $display("FAIL cfg_err bit %0d: got %b want %b", b, err, (b == 3)); end
            n_checks++;
            if (y_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_y_valid bit %0d: got %b want 0", b, y_valid); end
        end
        @(posedge clk);
        #1;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse: got %b want 0", err); end
        cfg_write(1'b0, 3, 3);
        cfg_write(1'b0, 4, 2);
    endtask
`endif

    task automatic test_reset_mid();
        y_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        pulse_reset();
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b want 0", y_valid); end
        send_bit(1'b0);
        n_checks++; if (y_valid !== 1'b1) begin n_fail++; $display("FAIL mid_reset_decode_valid: got %b want 1", y_valid); end
        n_checks++; if (y !== 3'd0)       begin n_fail++; $display("FAIL mid_reset_decode_y: got %0d want 0", y); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        y_ready = 1'b1;
        x       = 1'b0;
        x_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (y_valid !== 1'b1 || y !== 3'd0) begin
                n_fail++; $display("FAIL b2b cycle %0d: got valid=%b y=%0d want valid=1 y=0", i, y_valid, y);
            end
        end
        x_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++; if (y_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b want 0", y_valid); end
    endtask

    task automatic test_random();
        int  m_code, m_len, m_y, hit;
        bit  m_yv, m_err, exp_rdy, acc, take;
        pulse_reset();
        m_code = 0; m_len = 0; m_y = 0; m_yv = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            x_valid = ($urandom_range(0, 3) != 0);
            x       = 1'($urandom & 1);
            y_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !m_yv || y_ready;
            n_checks++;
            if (x_ready !== exp_rdy) begin n_fail++; $display("FAIL rnd_x_ready cyc %0d: got %b want %b", cyc, x_ready, exp_rdy); end
            @(posedge clk);
            take  = m_yv && y_ready;
            acc   = x_valid && exp_rdy;
            m_err = 0;
            if (take) m_yv = 0;
            if (acc) begin
                m_code = m_code * 2 + int'(x);
                m_len++;
                hit = -1;
                for (int e = 0; e < cb_val.size(); e++) begin
                    if (hit < 0 && cb_len[e] == m_len && cb_val[e] == m_code) hit = e;
                end
                if (hit >= 0) begin
                    if (hit >= NSYM) m_err = 1;
                    else begin m_y = m_sym[hit]; m_yv = 1; end
                    m_code = 0; m_len = 0;
                end else if (m_len == MAX_LEN) begin
                    m_err = 1; m_code = 0; m_len = 0;
                end
            end
            #1;
            n_checks++;
            if (y_valid !== m_yv || err !== m_err) begin
                n_fail++; $display("FAIL rnd_flags cyc %0d: got valid=%b err=%b want valid=%b err=%b", cyc, y_valid, err, m_yv, m_err);
            end
            if (m_yv) begin
                n_checks++;
                if (y !== SYM_W'(m_y)) begin n_fail++; $display("FAIL rnd_y cyc %0d: got %0d want %0d", cyc, y, m_y); end
            end
        end
        x_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        x = 1'b0; x_valid = 1'b0; y_ready = 1'b0;
        cfg_we = 1'b0; cfg_sel = 1'b0; cfg_addr = '0; cfg_data = '0;
        reset = 1'b0;
        m_count[1] = 1; m_count[2] = 0; m_count[3] = 3; m_count[4] = 2;
        for (int i = 0; i < NSYM; i++) m_sym[i] = i;
        build_codebook();

        test_reset();
        test_single_zero();
        test_streams();
        test_backpressure();
`ifdef HUFFDEC_CFG_EN
        test_cfg_err();
`endif
        test_reset_mid();
        test_back_to_back();
        test_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
